// File: rtl/stub_frame_pkg.sv
`default_nettype none
// ============================================================================
// Package  : stub_frame_pkg
// Brief    : Frame constants, emitter state encoding and frame-word helpers
//            shared by the layer stub framer and its bench.
// Revision : 1.0 - initial release
// ============================================================================
package stub_frame_pkg;

   localparam logic [2:0]  HDR_TAG = 3'b111;
   localparam logic [2:0]  TRL_TAG = 3'b000;
   localparam logic [24:0] HDR_LOW = 25'h1FF_FFFF;
   localparam logic [24:0] TRL_LOW = 25'h000_0000;

   localparam int CNT_W      = 6;
   localparam int NUM_LAYERS = 6;
   localparam int STUB_W     = 36;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEADER  = 3'd1,
      ST_COUNT   = 3'd2,
      ST_STUBS   = 3'd3,
      ST_TRAILER = 3'd4
   } emit_state_t;

   function automatic logic is_header(input logic [STUB_W-1:0] word);
      return (word[35:33] == HDR_TAG) && (word[24:0] == HDR_LOW);
   endfunction

   function automatic logic is_trailer(input logic [STUB_W-1:0] word);
      return (word[35:33] == TRL_TAG) && (word[24:0] == TRL_LOW);
   endfunction

endpackage
`default_nettype wire

// File: rtl/stub_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : stub_bank_ram
// Brief    : Simple dual-port RAM, one write port and one registered read
//            port (read data valid one cycle after the address).
// Revision : 1.0 - initial release
// ============================================================================
module stub_bank_ram #(
   parameter int DEPTH = 512,
   parameter int WIDTH = 36,
   parameter int AW    = 9
)(
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule
`default_nettype wire

// File: rtl/layer_stub_framer.sv
`default_nettype none
// ============================================================================
// Module   : layer_stub_framer
// Brief    : Collects layer-tagged stubs per event into a ping-pong banked RAM
//            and emits header / count word / stubs L1..L6 / trailer frames.
// Options  : LAYER_STUB_FRAMER_ZERO_SUPPRESS_EN - events with no stubs emit
//            no frame (event number still advances).
// Revision : 1.0 - initial release
// ============================================================================
module layer_stub_framer
   import stub_frame_pkg::*;
#(
   parameter int MAX_STUBS = 31,
   parameter int EVNUM_W   = 8
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              en_proc,
   input  logic              ev_start,
   input  logic              in_valid,
   input  logic [2:0]        in_layer,
   input  logic [STUB_W-1:0] in_stub,
   output logic [STUB_W-1:0] stubout,
   output logic              busy,
   output logic              drop_err,
   output logic [5:0]        layer_ovf
);

   localparam int AW = 9;

   // ---------------------------------------------------------------- state
   logic                 cbank;
   logic                 ebank;
   logic [CNT_W-1:0]     cnt [2][NUM_LAYERS];
   logic [CNT_W-1:0]     lat [NUM_LAYERS];
   logic [EVNUM_W-1:0]   ev_num;
   logic [EVNUM_W-1:0]   emit_num;
   logic [7:0]           remain;
   logic [2:0]           cur_layer;
   logic [4:0]           cur_idx;
   emit_state_t          state;
   emit_state_t          state_nxt;
   logic [STUB_W-1:0]    word_nxt;
   logic [STUB_W-1:0]    rd_data;

   // ------------------------------------------------------------ collector
   logic             ev_go;
   logic             swap;
   logic             discard;
   logic             suppress;
   logic             wbank;
   logic             layer_ok;
   logic             stub_ok;
   logic             take;
   logic             full;
   logic             wr_en;
   logic             ovf_hit;
   logic [CNT_W-1:0] base;
   logic [7:0]       closed_total;
   logic [1:0]       ev_inc;

   always_comb begin
      ev_go        = ev_start & en_proc;
      swap         = ev_go & (state == ST_IDLE);
      discard      = ev_go & (state != ST_IDLE);
      // A stub arriving with ev_start belongs to the window being opened.
      wbank        = swap ? ~cbank : cbank;
      layer_ok     = (in_layer != 3'd0) && (in_layer != 3'd7);
      stub_ok      = (in_stub[24:0] != 25'd0) && !is_header(in_stub);
      take         = in_valid & en_proc & layer_ok & stub_ok;
      base         = '0;
      closed_total = '0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
         if ((in_layer == 3'(l + 1)) && !ev_go) begin
            base = cnt[wbank][l];
         end
         closed_total = closed_total + 8'(cnt[cbank][l]);
      end
      full    = (base == CNT_W'(MAX_STUBS));
      wr_en   = take & ~full;
      ovf_hit = take & full;
   end

`ifdef LAYER_STUB_FRAMER_ZERO_SUPPRESS_EN
   assign suppress = swap & (closed_total == 8'd0);
`else
   assign suppress = 1'b0;
`endif

   assign ev_inc = 2'(state == ST_TRAILER) + 2'(discard) + 2'(suppress);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cbank     <= 1'b0;
         ebank     <= 1'b0;
         emit_num  <= '0;
         ev_num    <= '0;
         drop_err  <= 1'b0;
         layer_ovf <= '0;
         for (int l = 0; l < NUM_LAYERS; l++) begin
            lat[l]    <= '0;
            cnt[0][l] <= '0;
            cnt[1][l] <= '0;
         end
      end else begin
         if (swap) begin
            cbank    <= ~cbank;
            ebank    <= cbank;
            emit_num <= ev_num;
            for (int l = 0; l < NUM_LAYERS; l++) begin
               lat[l] <= cnt[cbank][l];
            end
         end
         for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < NUM_LAYERS; l++) begin
               if (ev_go && (wbank == 1'(b))) begin
                  cnt[b][l] <= '0;
               end
               if (wr_en && (wbank == 1'(b)) && (in_layer == 3'(l + 1))) begin
                  cnt[b][l] <= base + CNT_W'(1);
               end
            end
         end
         for (int l = 0; l < NUM_LAYERS; l++) begin
            if (ovf_hit && (in_layer == 3'(l + 1))) begin
               layer_ovf[l] <= 1'b1;
            end
         end
         if (discard) begin
            drop_err <= 1'b1;
         end
         ev_num <= ev_num + EVNUM_W'(ev_inc);
      end
   end

   // --------------------------------------------------------------- storage
   stub_bank_ram #(
      .DEPTH (512),
      .WIDTH (STUB_W),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr ({wbank, in_layer, base[4:0]}),
      .wdata (in_stub),
      .raddr ({ebank, cur_layer, cur_idx}),
      .rdata (rd_data)
   );

   // ---------------------------------------------------------- read cursor
   // The cursor addresses the stub that will be on stubout two edges later,
   // so empty layers are hopped over without inserting a bubble.
   logic [CNT_W-1:0] cur_cnt;
   logic [2:0]       first_layer;
   logic [2:0]       next_layer;

   always_comb begin
      cur_cnt     = '0;
      first_layer = 3'd7;
      next_layer  = 3'd7;
      for (int l = NUM_LAYERS - 1; l >= 0; l--) begin
         if (lat[l] != '0) begin
            first_layer = 3'(l + 1);
         end
         if ((lat[l] != '0) && (3'(l + 1) > cur_layer)) begin
            next_layer = 3'(l + 1);
         end
         if (3'(l + 1) == cur_layer) begin
            cur_cnt = lat[l];
         end
      end
   end

   // --------------------------------------------------------- emitter FSM
   always_comb begin
      state_nxt = state;
      word_nxt  = '0;
      unique case (state)
         ST_IDLE: begin
            if (swap && !suppress) begin
               state_nxt = ST_HEADER;
            end
         end
         ST_HEADER: begin
            word_nxt  = {HDR_TAG, emit_num, HDR_LOW};
            state_nxt = ST_COUNT;
         end
         ST_COUNT: begin
            word_nxt  = {lat[0], lat[1], lat[2], lat[3], lat[4], lat[5]};
            state_nxt = (remain == 8'd0) ? ST_TRAILER : ST_STUBS;
         end
         ST_STUBS: begin
            word_nxt = rd_data;
            if (remain == 8'd1) begin
               state_nxt = ST_TRAILER;
            end
         end
         ST_TRAILER: begin
            word_nxt  = {TRL_TAG, emit_num, TRL_LOW};
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         stubout   <= '0;
         busy      <= 1'b0;
         remain    <= '0;
         cur_layer <= 3'd0;
         cur_idx   <= 5'd0;
      end else begin
         state   <= state_nxt;
         stubout <= word_nxt;
         busy    <= (state != ST_IDLE);
         if (swap) begin
            remain <= closed_total;
         end else if (state == ST_STUBS) begin
            remain <= remain - 8'd1;
         end
         if (state == ST_HEADER) begin
            cur_layer <= first_layer;
            cur_idx   <= 5'd0;
         end else if ((state == ST_COUNT) || (state == ST_STUBS)) begin
            if (({1'b0, cur_idx} + CNT_W'(1)) < cur_cnt) begin
               cur_idx <= cur_idx + 5'd1;
            end else begin
               cur_layer <= next_layer;
               cur_idx   <= 5'd0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_layer_stub_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_stub_framer
// Brief    : Scoreboard bench for layer_stub_framer; frame words are predicted
//            when ev_start is driven and compared as the DUT emits them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_stub_framer;

   logic        clk = 1'b0;
   logic        reset;
   logic        en_proc;
   logic        ev_start;
   logic        in_valid;
   logic [2:0]  in_layer;
   logic [35:0] in_stub;
   logic [35:0] stubout;
   logic        busy;
   logic        drop_err;
   logic [5:0]  layer_ovf;

   layer_stub_framer dut (
      .clk       (clk),
      .reset     (reset),
      .en_proc   (en_proc),
      .ev_start  (ev_start),
      .in_valid  (in_valid),
      .in_layer  (in_layer),
      .in_stub   (in_stub),
      .stubout   (stubout),
      .busy      (busy),
      .drop_err  (drop_err),
      .layer_ovf (layer_ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  layer;
      logic [35:0] w;
   } stub_t;

   stub_t       m_q[$];
   int          m_cnt[6];
   logic [7:0]  ev_exp;
   logic [5:0]  ovf_exp;
   logic [35:0] exp_q[$];
   logic [35:0] cap[$];
   logic [35:0] mon_exp;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          busy_cyc = 0;
   bit          mon_en   = 1'b0;

   // Stream monitor: every busy cycle must carry the next predicted word,
   // every other cycle must be all zeros.
   always @(negedge clk) begin
      if (mon_en) begin
         n_checks++;
         if (busy) begin
            busy_cyc++;
            cap.push_back(stubout);
            if (exp_q.size() == 0) begin
               $display("FAIL stream_extra: got %h, no frame word expected", stubout);
            end else begin
               mon_exp = exp_q.pop_front();
               if (stubout !== mon_exp) begin
                  $display("FAIL stream_word: got %h, expected %h", stubout, mon_exp);
               end else begin
                  n_pass++;
               end
            end
         end else begin
            if (stubout !== 36'h0) begin
               $display("FAIL idle_zero: got %h, expected 000000000", stubout);
            end else begin
               n_pass++;
            end
         end
      end
   end

   function automatic logic [35:0] cap_at(input int i);
      return (i < cap.size()) ? cap[i] : 36'hx;
   endfunction

   task automatic m_clear();
      m_q.delete();
      for (int l = 0; l < 6; l++) m_cnt[l] = 0;
   endtask

   task automatic model_stub(input logic [2:0] lay, input logic [35:0] st);
      if (lay >= 3'd1 && lay <= 3'd6 && st[24:0] != 25'h0 &&
          !(st[35:33] == 3'b111 && st[24:0] == 25'h1FFFFFF)) begin
         if (m_cnt[lay - 3'd1] == 31) begin
            ovf_exp[lay - 3'd1] = 1'b1;
         end else begin
            m_q.push_back('{layer: lay, w: st});
            m_cnt[lay - 3'd1]++;
         end
      end
   endtask

   task automatic model_ev(input bit drop);
      int          total;
      logic [35:0] cw;
      if (drop) begin
         m_clear();
         ev_exp++;
         return;
      end
      total = 0;
      cw    = '0;
      for (int l = 0; l < 6; l++) begin
         total += m_cnt[l];
         cw = {cw[29:0], 6'(m_cnt[l])};
      end
`ifdef LAYER_STUB_FRAMER_ZERO_SUPPRESS_EN
      if (total == 0) begin
         ev_exp++;
         m_clear();
         return;
      end
`endif
      exp_q.push_back({3'b111, ev_exp, 25'h1FFFFFF});
      exp_q.push_back(cw);
      for (int l = 1; l <= 6; l++) begin
         foreach (m_q[i]) begin
            if (m_q[i].layer == 3'(l)) exp_q.push_back(m_q[i].w);
         end
      end
      exp_q.push_back({3'b000, ev_exp, 25'h0});
      ev_exp++;
      m_clear();
   endtask

   // Called at posedge+1; drives one cycle of inputs and updates the model.
   task automatic drive(input bit ev, input bit ev_drop, input bit vld,
                        input logic [2:0] lay, input logic [35:0] st);
      if (ev)  model_ev(ev_drop);
      if (vld) model_stub(lay, st);
      ev_start = ev;
      in_valid = vld;
      in_layer = lay;
      in_stub  = st;
      @(posedge clk);
      #1;
      ev_start = 1'b0;
      in_valid = 1'b0;
      in_layer = 3'd0;
      in_stub  = 36'h0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n >= budget) begin
         $display("FAIL frame_timeout: %0d words still pending after %0d cycles", exp_q.size(), budget);
      end else begin
         n_pass++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #12;
      n_checks += 4;
      if (stubout !== 36'h0)  $display("FAIL rst_stubout: got %h, expected 0", stubout);  else n_pass++;
      if (busy !== 1'b0)      $display("FAIL rst_busy: got %b, expected 0", busy);         else n_pass++;
      if (drop_err !== 1'b0)  $display("FAIL rst_drop_err: got %b, expected 0", drop_err); else n_pass++;
      if (layer_ovf !== 6'h0) $display("FAIL rst_layer_ovf: got %b, expected 0", layer_ovf); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
   endtask

   task automatic test_basic();
      cap.delete();
      busy_cyc = 0;
      drive(0, 0, 1, 3'd1, 36'h000000101);
      drive(0, 0, 1, 3'd1, 36'h000000102);
      drive(0, 0, 1, 3'd3, 36'h000000301);
      drive(1, 0, 0, 3'd0, 36'h0);
      wait_done(40);
      n_checks += 4;
      if (busy_cyc !== 6) $display("FAIL basic_busy_len: got %0d, expected 6", busy_cyc); else n_pass++;
      if (cap_at(0) !== 36'hE01FFFFFF) $display("FAIL basic_header: got %h, expected E01FFFFFF", cap_at(0)); else n_pass++;
      if (cap_at(1) !== 36'h080040000) $display("FAIL basic_count: got %h, expected 080040000", cap_at(1)); else n_pass++;
      if (cap_at(5) !== 36'h000000000) $display("FAIL basic_trailer: got %h, expected 000000000", cap_at(5)); else n_pass++;
   endtask

   task automatic test_empty();
      cap.delete();
      drive(1, 0, 0, 3'd0, 36'h0);
      wait_done(20);
`ifdef LAYER_STUB_FRAMER_ZERO_SUPPRESS_EN
      n_checks++;
      if (cap.size() != 0) $display("FAIL empty_suppressed: got %0d words, expected 0", cap.size()); else n_pass++;
`else
      n_checks += 3;
      if (cap.size() != 3) $display("FAIL empty_len: got %0d words, expected 3", cap.size()); else n_pass++;
      if (cap_at(0) !== 36'hE03FFFFFF) $display("FAIL empty_header: got %h, expected E03FFFFFF", cap_at(0)); else n_pass++;
      if (cap_at(2) !== 36'h002000000) $display("FAIL empty_trailer: got %h, expected 002000000", cap_at(2)); else n_pass++;
`endif
      cap.delete();
      drive(0, 0, 1, 3'd5, 36'h000000501);
      drive(1, 0, 0, 3'd0, 36'h0);
      wait_done(20);
      n_checks++;
      if (cap_at(0) !== 36'hE05FFFFFF) $display("FAIL empty_next_header: got %h, expected E05FFFFFF", cap_at(0)); else n_pass++;
   endtask

   task automatic test_overflow();
      cap.delete();
      for (int i = 0; i < 33; i++) drive(0, 0, 1, 3'd2, 36'h000000200 + 36'(i + 1));
      drive(1, 0, 0, 3'd0, 36'h0);
      wait_done(80);
      n_checks += 3;
      if (layer_ovf !== 6'b000010) $display("FAIL ovf_flag: got %b, expected 000010", layer_ovf); else n_pass++;
      if (cap.size() != 34) $display("FAIL ovf_len: got %0d words, expected 34", cap.size()); else n_pass++;
      if (cap_at(1) !== 36'h01F000000) $display("FAIL ovf_count: got %h, expected 01F000000", cap_at(1)); else n_pass++;
   endtask

   task automatic test_filter();
      cap.delete();
      drive(0, 0, 1, 3'd0, 36'h000000111);
      drive(0, 0, 1, 3'd7, 36'h000000777);
      drive(0, 0, 1, 3'd1, 36'h0FE000000);
      drive(0, 0, 1, 3'd4, 36'hE55FFFFFF);
      en_proc  = 1'b0;
      ev_start = 1'b1;
      in_valid = 1'b1;
      in_layer = 3'd2;
      in_stub  = 36'h000000222;
      @(posedge clk);
      #1;
      en_proc  = 1'b1;
      ev_start = 1'b0;
      in_valid = 1'b0;
      drive(0, 0, 1, 3'd6, 36'h000000601);
      drive(1, 0, 0, 3'd0, 36'h0);
      wait_done(30);
      n_checks += 4;
      if (cap.size() != 4) $display("FAIL filter_len: got %0d words, expected 4", cap.size()); else n_pass++;
      if (cap_at(1) !== 36'h000000001) $display("FAIL filter_count: got %h, expected 000000001", cap_at(1)); else n_pass++;
      if (cap_at(2) !== 36'h000000601) $display("FAIL filter_stub: got %h, expected 000000601", cap_at(2)); else n_pass++;
      if (layer_ovf !== ovf_exp) $display("FAIL filter_ovf: got %b, expected %b", layer_ovf, ovf_exp); else n_pass++;
   endtask

   task automatic test_same_cycle();
      cap.delete();
      drive(0, 0, 1, 3'd1, 36'h000000A01);
      drive(1, 0, 1, 3'd2, 36'h000000B02);
      wait_done(30);
      n_checks += 2;
      if (cap.size() != 4) $display("FAIL same_len: got %0d words, expected 4", cap.size()); else n_pass++;
      if (cap_at(2) !== 36'h000000A01) $display("FAIL same_old: got %h, expected 000000A01", cap_at(2)); else n_pass++;
      cap.delete();
      drive(1, 0, 0, 3'd0, 36'h0);
      wait_done(30);
      n_checks += 2;
      if (cap_at(1) !== 36'h001000000) $display("FAIL same_count: got %h, expected 001000000", cap_at(1)); else n_pass++;
      if (cap_at(2) !== 36'h000000B02) $display("FAIL same_new: got %h, expected 000000B02", cap_at(2)); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] base_ev;
      base_ev = ev_exp;
      cap.delete();
      busy_cyc = 0;
      for (int l = 1; l <= 6; l++) begin
         for (int i = 0; i < 31; i++) drive(0, 0, 1, 3'(l), {4'h1, 20'h0, 4'(l), 8'(i + 1)});
      end
      drive(1, 0, 0, 3'd0, 36'h0);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 3'd3, 36'h000000C01 + 36'(i));
      repeat (46) drive(0, 0, 0, 3'd0, 36'h0);
      drive(1, 1, 0, 3'd0, 36'h0);
      n_checks++;
      if (drop_err !== 1'b1) $display("FAIL drop_flag_now: got %b, expected 1", drop_err); else n_pass++;
      wait_done(300);
      n_checks += 3;
      if (busy_cyc !== 189) $display("FAIL drop_busy_len: got %0d, expected 189", busy_cyc); else n_pass++;
      if (cap.size() != 189) $display("FAIL drop_frame_len: got %0d words, expected 189", cap.size()); else n_pass++;
      if (drop_err !== 1'b1) $display("FAIL drop_flag_sticky: got %b, expected 1", drop_err); else n_pass++;
      cap.delete();
      drive(0, 0, 1, 3'd1, 36'h000000D01);
      drive(1, 0, 0, 3'd0, 36'h0);
      wait_done(30);
      n_checks++;
      if (cap_at(0) !== {3'b111, 8'(base_ev + 8'd2), 25'h1FFFFFF})
         $display("FAIL drop_next_header: got %h, expected %h", cap_at(0), {3'b111, 8'(base_ev + 8'd2), 25'h1FFFFFF});
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      cap.delete();
      for (int i = 0; i < 20; i++) drive(0, 0, 1, 3'd1, 36'h000000E00 + 36'(i + 1));
      drive(1, 0, 0, 3'd0, 36'h0);
      drive(0, 0, 1, 3'd2, 36'h000000E77);
      repeat (8) @(posedge clk);
      #3;
      mon_en = 1'b0;
      reset  = 1'b0;
      #1;
      n_checks += 4;
      if (stubout !== 36'h0)  $display("FAIL midrst_stubout: got %h, expected 0", stubout); else n_pass++;
      if (busy !== 1'b0)      $display("FAIL midrst_busy: got %b, expected 0", busy); else n_pass++;
      if (drop_err !== 1'b0)  $display("FAIL midrst_drop_err: got %b, expected 0", drop_err); else n_pass++;
      if (layer_ovf !== 6'h0) $display("FAIL midrst_layer_ovf: got %b, expected 0", layer_ovf); else n_pass++;
      exp_q.delete();
      m_clear();
      ev_exp  = 8'd0;
      ovf_exp = 6'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      cap.delete();
      drive(0, 0, 1, 3'd4, 36'h000000F04);
      drive(1, 0, 0, 3'd0, 36'h0);
      wait_done(30);
      n_checks += 4;
      if (cap.size() != 4) $display("FAIL midrst_len: got %0d words, expected 4", cap.size()); else n_pass++;
      if (cap_at(0) !== 36'hE01FFFFFF) $display("FAIL midrst_header: got %h, expected E01FFFFFF", cap_at(0)); else n_pass++;
      if (cap_at(1) !== 36'h000001000) $display("FAIL midrst_count: got %h, expected 000001000", cap_at(1)); else n_pass++;
      if (cap_at(2) !== 36'h000000F04) $display("FAIL midrst_stub: got %h, expected 000000F04", cap_at(2)); else n_pass++;
   endtask

   initial begin
      reset    = 1'b0;
      en_proc  = 1'b1;
      ev_start = 1'b0;
      in_valid = 1'b0;
      in_layer = 3'd0;
      in_stub  = 36'h0;
      ev_exp   = 8'd0;
      ovf_exp  = 6'd0;
      m_clear();
      test_reset();
      test_basic();
      test_empty();
      test_overflow();
      test_filter();
      test_same_cycle();
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/layer_stub_framer.md
Name: layer_stub_framer

Overview:
- Upstream neighbour of the per-layer stub router. Collects stubs tagged with a layer number (1..6) during an event window.
- At each event boundary it emits the framed 36-bit stream the router consumes: header, per-layer count word, stubs grouped L1..L6, trailer, then idle zeros.
- Ping-pong banked so that collection of event N+1 overlaps emission of event N.

Parameters:
- MAX_STUBS, 31, max stubs kept per layer per event; legal range 1..31 so that no count field exceeds 6'd31.
- EVNUM_W, 8, width of the event number carried in header and trailer bits [32:25]; fixed at 8.

Ports:
- clk, input, 1, single clock.
- reset, input, 1, asynchronous, active-low.
- en_proc, input, 1, processing enable; when low, in_valid and ev_start are ignored and emission continues.
- ev_start, input, 1, single-cycle pulse that closes the current collection window.
- in_valid, input, 1, in_stub/in_layer qualified this cycle.
- in_layer, input, 3, target layer 1..6; 0 and 7 are dropped.
- in_stub, input, 36, stub word.
- stubout, output, 36, framed stream; 0 when idle.
- busy, output, 1, emitter not in IDLE.
- drop_err, output, 1, sticky; an event was discarded because of overrun.
- layer_ovf, output, 6, sticky per layer (bit0 = L1); at least one stub dropped because the layer was full.

Behaviour:
- Reset (async, reset=0): stubout=0, busy=0, drop_err=0, layer_ovf=0. Counts cleared, ev_num=0, collect bank=0, FSM=IDLE.
- Reset is effective mid-frame: stubout returns to 0 immediately and no partial frame resumes.
- Storage: one 512x36 RAM addressed {bank, layer[2:0], idx[4:0]}. Write port used by the collector, read port by the emitter. Read latency is 1 cycle.
- Collect: on in_valid & en_proc with a legal layer, write to cnt[layer] in the collect bank, then increment cnt.
- Collect drop rules:
  - cnt == MAX_STUBS: drop the stub and set layer_ovf[layer].
  - in_stub[24:0]==0, or in_stub matches the header pattern ([35:33]==3'b111 & [24:0]==25'h1FFFFFF): drop silently.
- ev_start & en_proc, emitter IDLE:
  - Swap banks and latch the six counts of the closed bank.
  - Clear the counts of the new collect bank.
  - FSM goes to HEADER.
- ev_start while busy: no swap. Clear the collect-bank counts (the event is discarded), set drop_err, increment ev_num.
- ev_start and in_valid in the same cycle: the stub belongs to the new window (new collect bank).
- FSM states: IDLE -> HEADER -> COUNT -> STUBS -> TRAILER -> IDLE.
  - HEADER: stubout = {3'b111, ev_num, 25'h1FFFFFF}.
  - COUNT: stubout = {c1,c2,c3,c4,c5,c6}, 6 bits each, c1 in [35:30].
  - STUBS: layers in order L1..L6, index 0..c-1, one word per cycle, no gaps. Empty layers are skipped with no bubble, which requires prefetch one cycle ahead.
  - TRAILER: stubout = {3'b000, ev_num, 25'h0}. ev_num increments on leaving TRAILER and wraps at 255.
- Latency: ev_start sampled at edge k gives the header valid after edge k+1 and the count word after k+2. The first stub follows at k+3, or the trailer if all counts are 0.
- Frame length: 3 + sum(c) cycles, maximum 189. busy is high from edge k+1 through the TRAILER cycle.
- stubout is registered and is 0 in every cycle it is not driving a frame word.

Optional Feature:
- Macro: LAYER_STUB_FRAMER_ZERO_SUPPRESS_EN.
- Defined: an event whose six counts are all 0 emits no frame. The FSM stays IDLE, stubout stays 0, ev_num still increments.
- Undefined: every accepted event emits at least header, count word and trailer (3 words).

Decomposition:
- Shared package stub_frame_pkg:
  - HDR_TAG=3'b111, HDR_LOW=25'h1FFFFFF, TRL_LOW=25'h0.
  - CNT_W=6, NUM_LAYERS=6, STUB_W=36.
  - Emitter state enum.
  - Helper functions is_header(word) and is_trailer(word).
- One sub-module: stub_bank_ram, a simple dual-port 512x36 RAM with registered read.
- Collector, count registers and emit FSM stay in the top level.

Test Plan:
- Event 0 with L1 stubs 36'h000000101 and 36'h000000102, L3 stub 36'h000000301, then ev_start. Required stream:
  - E01FFFFFF, 080040000, 000000101, 000000102, 000000301, 000000000 (trailer ev 0).
  - Then idle 0.
  - busy is high for exactly 6 cycles.
- Empty event, macro undefined -> E01FFFFFF, 000000000, 000000000. With the macro defined -> no frame, and the next header carries ev_num=1 (E03FFFFFF).
- 33 stubs to L2 -> count word field c2=31 (000000000 | 31<<24 = 01F000000), 31 stubs emitted, layer_ovf=6'b000010.
- Second ev_start 50 cycles into a 189-word frame -> the frame completes intact, drop_err=1, the next header carries ev_num+2.
- Async reset asserted during STUBS -> stubout=0 in the same cycle. After release, the next ev_start emits header ev_num=0 with counts from post-reset stubs only.
- in_layer=0 or 7, and a stub with [24:0]==0 -> not counted and not emitted; layer_ovf unchanged.
